// File: rtl/mfd_pkg.sv
// Shared types and helpers for the Manchester frame decoder.
// Optional feature macro: FRAME_PARITY_EN adds the PARITY state to the FSM.
package mfd_pkg;

`ifdef FRAME_PARITY_EN
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        HUNT = 2'd0,
        DATA = 2'd1,
        DONE = 2'd3
    } state_t;
`endif

    // Width of a timer that must be able to hold 0 .. 3*half_bit_cycles.
    function automatic int timer_width(input int half_bit_cycles);
        return $clog2(3 * half_bit_cycles + 1);
    endfunction

endpackage

// File: rtl/manchester_bit_recovery.sv
// Bit recovery: synchronizes the Manchester line, finds mid-bit edges by
// timing, and emits one decoded bit per accepted edge plus a timeout strobe.
module manchester_bit_recovery
    import mfd_pkg::*;
#(
    parameter int HALF_BIT_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic digital_in,
    output logic bit_value,
    output logic bit_strobe,
    output logic timeout,
    output logic manchester_clock
);

    localparam int            TW         = timer_width(HALF_BIT_CYCLES);
    localparam logic [TW-1:0] ACCEPT_MIN = TW'(3 * HALF_BIT_CYCLES / 2);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(3 * HALF_BIT_CYCLES);

    logic          sync_meta;
    logic          sync_line;
    logic          line_prev;
    logic [TW-1:0] timer;
    logic          line_edge;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments make each stage take the previous
        // stage's old value, which is what builds a real shift chain.
        if (reset) begin
            sync_meta <= 1'b0;
            sync_line <= 1'b0;
            line_prev <= 1'b0;
        end else begin
            sync_meta <= digital_in;
            sync_line <= sync_meta;
            line_prev <= sync_line;
        end
    end

    // Edges close to the previous accepted edge are bit boundaries; the first
    // late-enough edge is mid-bit and its direction is the bit value.
    assign line_edge  = sync_line ^ line_prev;
    assign bit_strobe = line_edge && (timer >= ACCEPT_MIN);
    assign bit_value  = sync_line;
    // Accepted edge wins over a timeout landing in the same cycle.
    assign timeout    = (timer == TIMER_MAX - 1'b1) && !bit_strobe;

    // Saturating timer measuring time since the last accepted edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            timer <= '0;
        end else if (bit_strobe) begin
            timer <= '0;
        end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    // Recovered bit clock toggles once per decoded bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            manchester_clock <= 1'b0;
        end else if (bit_strobe) begin
            manchester_clock <= ~manchester_clock;
        end
    end

endmodule

// File: rtl/manchester_frame_decoder.sv
// Manchester frame decoder: hunts for a sync word, collects a fixed-length
// payload and publishes it with a one-cycle valid pulse.
// Optional feature macro: FRAME_PARITY_EN appends an even-parity bit check.
module manchester_frame_decoder
    import mfd_pkg::*;
#(
    parameter int                       HALF_BIT_CYCLES = 8,
    parameter int                       PREAMBLE_BITS   = 16,
    parameter logic [PREAMBLE_BITS-1:0] PREAMBLE        = 16'h5A5A,
    parameter int                       FRAME_BITS      = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  digital_in,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic                  frame_valid,
    output logic                  frame_error,
    output logic                  manchester_clock,
    output logic                  busy
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    state_t                   state;
    state_t                   next_state;
    logic                     bit_value;
    logic                     bit_strobe;
    logic                     timeout;
    logic [PREAMBLE_BITS-1:0] preamble_sr;
    logic [PREAMBLE_BITS-1:0] preamble_next;
    logic                     preamble_match;
    logic [FRAME_BITS-1:0]    payload_sr;
    logic [CW-1:0]            bit_count;
    logic                     last_bit;
    logic                     load_frame;
    logic                     error_set;
`ifdef FRAME_PARITY_EN
    logic                     parity_ok;
`endif

    manchester_bit_recovery #(
        .HALF_BIT_CYCLES (HALF_BIT_CYCLES)
    ) u_bit_recovery (
        .clock            (clock),
        .reset            (reset),
        .digital_in       (digital_in),
        .bit_value        (bit_value),
        .bit_strobe       (bit_strobe),
        .timeout          (timeout),
        .manchester_clock (manchester_clock)
    );

    assign preamble_next  = {preamble_sr[PREAMBLE_BITS-2:0], bit_value};
    assign preamble_match = (preamble_next == PREAMBLE);
    assign last_bit       = (bit_count == CW'(FRAME_BITS - 1));
`ifdef FRAME_PARITY_EN
    // Even parity: payload plus parity bit must XOR to zero.
    assign parity_ok      = ~(^payload_sr ^ bit_value);
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: defaulting next_state before the case keeps this purely
        // combinational; a path that leaves it unassigned would infer a latch.
        next_state = state;
        case (state)
            HUNT: begin
                if (bit_strobe && preamble_match) next_state = DATA;
            end
            DATA: begin
                if (bit_strobe && last_bit) begin
`ifdef FRAME_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = DONE;
`endif
                end else if (timeout) begin
                    next_state = HUNT;
                end
            end
`ifdef FRAME_PARITY_EN
            PARITY: begin
                if (bit_strobe)   next_state = parity_ok ? DONE : HUNT;
                else if (timeout) next_state = HUNT;
            end
`endif
            DONE:    next_state = HUNT;
            default: next_state = HUNT;
        endcase
    end

    // Output decode: busy level, frame load and error requests.
    always_comb begin
        busy       = (state == DATA);
        load_frame = (state == DONE);
        error_set  = (state == DATA) && timeout;
`ifdef FRAME_PARITY_EN
        busy       = busy || (state == PARITY);
        error_set  = error_set
                   || ((state == PARITY) && (timeout || (bit_strobe && !parity_ok)));
`endif
    end

    // Shift registers, bit counter and registered frame outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            preamble_sr <= '0;
            payload_sr  <= '0;
            bit_count   <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_valid <= load_frame;
            frame_error <= error_set;
            if (load_frame) frame_data <= payload_sr;
            case (state)
                HUNT: begin
                    bit_count <= '0;
                    // A match consumes the sync word so it cannot be reused.
                    if (bit_strobe)   preamble_sr <= preamble_match ? '0 : preamble_next;
                    else if (timeout) preamble_sr <= '0;
                end
                DATA: begin
                    if (bit_strobe) begin
                        payload_sr <= {payload_sr[FRAME_BITS-2:0], bit_value};
                        bit_count  <= bit_count + 1'b1;
                    end
                end
                DONE:    preamble_sr <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_manchester_frame_decoder.sv
// Scoreboard bench for manchester_frame_decoder: stimulus pushes expected
// frame events, a monitor pops and compares on every valid/error pulse.
module tb_manchester_frame_decoder;

    localparam int H = 8;
    localparam int P = 16;
    localparam int F = 64;
`ifdef FRAME_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam logic [15:0] SYNC = 16'h5A5A;
    localparam logic [63:0] D1   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] D2   = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] D3   = 64'hA5C3_0F96_1248_E7B1;
    localparam logic [63:0] D4   = 64'h0F0F_3C3C_5555_00FF;

    logic        clock = 1'b0;
    logic        reset;
    logic        digital_in;
    logic [63:0] frame_data;
    logic        frame_valid;
    logic        frame_error;
    logic        manchester_clock;
    logic        busy;

    typedef struct packed {
        logic        is_error;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   mclk_toggles = 0;
    int   jitter_on = 0;
    int   jit_idx = 0;
    int   jitter_tab[8] = '{2, -2, -1, 2, -2, 1, 0, -1};

    manchester_frame_decoder #(
        .HALF_BIT_CYCLES (H),
        .PREAMBLE_BITS   (P),
        .PREAMBLE        (SYNC),
        .FRAME_BITS      (F)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .digital_in       (digital_in),
        .frame_data       (frame_data),
        .frame_valid      (frame_valid),
        .frame_error      (frame_error),
        .manchester_clock (manchester_clock),
        .busy             (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One half-bit at the given level, optionally jittered.
    task automatic drive_half(input logic level);
        int n;
        n = H;
        if (jitter_on != 0) begin
            n = H + jitter_tab[jit_idx];
            jit_idx = (jit_idx + 1) % 8;
        end
        digital_in = level;
        repeat (n) @(negedge clock);
    endtask

    // IEEE 802.3: a 1 is low then high, a 0 is high then low.
    task automatic send_bit(input logic b);
        drive_half(~b);
        drive_half(b);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic idle(input int n);
        digital_in = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [15:0] sync_word, input logic [63:0] data,
                              input logic parity_flip);
        send_bits({48'd0, sync_word}, P);
        send_bits(data, F);
`ifdef FRAME_PARITY_EN
        send_bit(^data ^ parity_flip);
`else
        if (parity_flip) $display("note: parity flip ignored without parity");
`endif
    endtask

    // Monitor: count recovered-clock toggles, score every frame event.
    initial begin
        logic mclk_prev;
        exp_t e;
        mclk_prev = 1'b0;
        forever begin
            @(negedge clock);
            if (manchester_clock !== mclk_prev) mclk_toggles++;
            mclk_prev = manchester_clock;
            if (frame_valid === 1'b1 || frame_error === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: valid=%b error=%b data=%h, none expected",
                             frame_valid, frame_error, frame_data);
                end else begin
                    e = exp_q.pop_front();
                    check("event_is_error", {63'd0, frame_error}, {63'd0, e.is_error});
                    check("event_frame_data", frame_data, e.data);
                    if (e.is_error) check("busy_after_error", {63'd0, busy}, 64'd0);
                end
            end
        end
    end

    initial begin
        int t0;
        reset      = 1'b1;
        digital_in = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_frame_data", frame_data, 64'd0);
        check("reset_frame_valid", {63'd0, frame_valid}, 64'd0);
        check("reset_frame_error", {63'd0, frame_error}, 64'd0);
        check("reset_mclk", {63'd0, manchester_clock}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        idle(40);

        // Clean frame.
        exp_q.push_back('{1'b0, D1});
        t0 = mclk_toggles;
        send_frame(SYNC, D1, 1'b0);
        check("frame1_mclk_toggles", 64'(mclk_toggles - t0), 64'(P + F + PAR));
        idle(40);

        // Line stalls after 10 payload bits: error, previous data kept.
        exp_q.push_back('{1'b1, D1});
        send_bits({48'd0, SYNC}, P);
        send_bits({54'd0, D2[63:54]}, 10);
        check("busy_mid_frame", {63'd0, busy}, 64'd1);
        repeat (40) @(negedge clock);
        idle(40);

        // Jittered timing.
        exp_q.push_back('{1'b0, D3});
        jitter_on = 1;
        t0 = mclk_toggles;
        send_frame(SYNC, D3, 1'b0);
        jitter_on = 0;
        check("jitter_mclk_toggles", 64'(mclk_toggles - t0), 64'(P + F + PAR));
        idle(40);

        // Wrong sync word is ignored silently; the next good frame decodes.
        send_frame(16'h5A5B, D1, 1'b0);
        idle(40);
        exp_q.push_back('{1'b0, D4});
        send_frame(SYNC, D4, 1'b0);
        idle(40);

        // Reset in the middle of a payload discards it.
        send_bits({48'd0, SYNC}, P);
        send_bits({34'd0, D2[63:34]}, 30);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_frame_data", frame_data, 64'd0);
        check("midreset_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        idle(40);
        exp_q.push_back('{1'b0, D2});
        send_frame(SYNC, D2, 1'b0);
        idle(40);

`ifdef FRAME_PARITY_EN
        // Payload 1 with parity bit 0 is odd: error; with parity bit 1: valid.
        exp_q.push_back('{1'b1, D2});
        send_frame(SYNC, 64'h1, 1'b1);
        idle(40);
        exp_q.push_back('{1'b0, 64'h1});
        send_frame(SYNC, 64'h1, 1'b0);
        idle(40);
`endif

        idle(60);
        check("pending_expectations", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/manchester_frame_decoder.md
MANCHESTER_FRAME_DECODER -- requirements
Module: manchester_frame_decoder

Interface
REQ-001 Parameter HALF_BIT_CYCLES, default 8: clock cycles per Manchester half-bit; legal range 4..255.
REQ-002 Parameter PREAMBLE_BITS, default 16: width of the sync word.
REQ-003 Parameter PREAMBLE, default 16'h5A5A: sync word, MSB first.
REQ-004 Parameter FRAME_BITS, default 64: payload bits per frame, MSB first.
REQ-005 Port clock  input  1  single clock for all logic; every register updates on its rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port digital_in  input  1  asynchronous Manchester line.
REQ-008 Port frame_data  output  FRAME_BITS  last good payload; holds until the next good frame.
REQ-009 Port frame_valid  output  1  one-cycle pulse when frame_data updates.
REQ-010 Port frame_error  output  1  one-cycle pulse on a timing or parity error.
REQ-011 Port manchester_clock  output  1  recovered bit clock; toggles at each accepted mid-bit edge.
REQ-012 Port busy  output  1  high in the DATA and PARITY states.

Function
REQ-013 digital_in SHALL pass through a 2-flop synchronizer; edge detection uses the synchronized value against its 1-cycle delay.
REQ-014 Line coding SHALL be IEEE 802.3: a rising mid-bit edge is 1 and a falling mid-bit edge is 0.
REQ-015 A timer SHALL restart at 0 on each accepted mid-bit edge; edges with timer < 3*HALF_BIT_CYCLES/2 (integer division) are bit-boundary edges and SHALL be ignored.
REQ-016 The first edge with timer >= 3*HALF_BIT_CYCLES/2 SHALL be accepted as a mid-bit edge and yield one bit.
REQ-017 The timer SHALL saturate; reaching 3*HALF_BIT_CYCLES with no accepted edge is a timeout.
REQ-018 The FSM SHALL have the states HUNT, DATA, PARITY (only with the macro) and DONE.
REQ-019 In HUNT, each bit SHALL shift into a PREAMBLE_BITS register; on a full match the FSM enters DATA and clears the bit count.
REQ-020 In DATA, bits SHALL shift into the payload register; after FRAME_BITS bits it enters PARITY if the macro is defined, otherwise DONE.
REQ-021 DONE SHALL last exactly one cycle: frame_data loads, frame_valid pulses, and the next state is HUNT with the preamble register cleared.
REQ-022 Latency: frame_valid SHALL assert 2 cycles after the cycle in which the last payload or parity edge is detected.
REQ-023 A timeout in DATA or PARITY SHALL pulse frame_error, leave frame_data unchanged and return to HUNT.
REQ-024 A timeout in HUNT SHALL only clear the preamble register and SHALL NOT pulse frame_error.
REQ-025 Preamble bits are consumed by the match: a frame that immediately follows DONE SHALL need a full new preamble.
REQ-026 If a timeout and an edge occur in the same cycle, the edge SHALL take priority.

Reset
REQ-027 While reset is high: frame_data = 0, frame_valid = 0, frame_error = 0, manchester_clock = 0, busy = 0, state = HUNT, timer and all shift registers = 0, synchronizer = 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame without pulsing frame_valid or frame_error.

Configuration
REQ-029 With FRAME_PARITY_EN defined, one even-parity bit SHALL follow the payload; parity over payload plus parity bit equal to 0 gives DONE, otherwise frame_error and HUNT.
REQ-030 Without FRAME_PARITY_EN, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to DONE.

Structure
REQ-031 A shared package mfd_pkg SHALL hold the FSM state enum and the timer-width function, clog2(3*HALF_BIT_CYCLES+1).
REQ-032 The bit-recovery logic (synchronizer, edge detect, timer, manchester_clock, bit/bit_strobe outputs) SHALL be the sub-module manchester_bit_recovery; the framing FSM stays in the top module.

Verification
REQ-033 Default parameters, preamble 16'h5A5A then payload 64'h0123_4567_89AB_CDEF -> one frame_valid pulse; frame_data = 64'h0123_4567_89AB_CDEF; frame_error stays 0.
REQ-034 Line held constant for 24 cycles after 10 payload bits -> frame_error pulses once, busy falls, and frame_data keeps its previous value.
REQ-035 Bit timing jittered by +/-2 cycles per half-bit (HALF_BIT_CYCLES=8) -> payload decodes correctly.
REQ-036 Preamble 16'h5A5B then a valid frame -> no frame_valid for the first frame and no frame_error.
REQ-037 Reset pulsed for 1 cycle at payload bit 30, then a full new frame -> exactly one frame_valid, for the new frame only.
REQ-038 FRAME_PARITY_EN defined, payload 64'h1 with parity bit 0 -> frame_error; the same payload with parity bit 1 -> frame_valid.
